// File: rtl/deserializer.sv
// Reassembles the serializer's bit stream into a parallel word plus bit-count modifier.
// Optional macro DESER_LSB_FIRST_EN: first bit lands at data_o[0] (right-aligned) instead of MSB-first.
module deserializer #(
    parameter int WIDTH = 16,
    parameter int MOD_W = 4
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    input  logic             ser_busy_i,
    output logic [WIDTH-1:0] data_o,
    output logic [MOD_W-1:0] data_mod_o,
    output logic             data_val_o,
    output logic             busy_o
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [MOD_W-1:0] TOP_IDX = MOD_W'(WIDTH - 1);
    localparam logic [MOD_W:0]   FULL    = (MOD_W+1)'(WIDTH);
    localparam logic [MOD_W:0]   MIN_CNT = (MOD_W+1)'(3);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [MOD_W:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [MOD_W-1:0]   mod_q, mod_d;
    logic               val_q, val_d;

    logic               capture;
    logic [MOD_W:0]     base_cnt;
    logic [MOD_W:0]     new_cnt;
    logic [MOD_W-1:0]   pos;
    logic [WIDTH-1:0]   new_shift;
    logic               fin;
    logic [WIDTH-1:0]   fin_data;
    logic [MOD_W:0]     fin_cnt;

    assign capture  = ser_busy_i & ser_data_val_i;
    // A frame always starts from an empty register, even when IDLE lasts zero cycles.
    assign base_cnt = (state_q == IDLE) ? '0 : cnt_q;
    assign new_cnt  = base_cnt + 1'b1;

`ifdef DESER_LSB_FIRST_EN
    assign pos = base_cnt[MOD_W-1:0];
`else
    assign pos = TOP_IDX - base_cnt[MOD_W-1:0];
`endif

    always_comb begin
        new_shift      = (state_q == IDLE) ? '0 : shift_q;
        new_shift[pos] = ser_data_i;
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        mod_d    = mod_q;
        val_d    = 1'b0;
        fin      = 1'b0;
        fin_data = shift_q;
        fin_cnt  = cnt_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    shift_d = new_shift;
                    cnt_d   = new_cnt;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!ser_busy_i) begin
                    fin = 1'b1;
                end else if (ser_data_val_i) begin
                    if (new_cnt == FULL) begin
                        fin      = 1'b1;
                        fin_data = new_shift;
                        fin_cnt  = new_cnt;
                    end else begin
                        shift_d = new_shift;
                        cnt_d   = new_cnt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
            // 1- and 2-bit frames are dropped silently, mirroring the serializer.
            if (fin_cnt >= MIN_CNT) begin
                data_d = fin_data;
                mod_d  = fin_cnt[MOD_W-1:0];
                val_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    assign data_o     = data_q;
    assign data_mod_o = mod_q;
    assign data_val_o = val_q;
    assign busy_o     = (state_q == COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus pushes expected frames, a negedge monitor pops and checks.
module tb_deserializer;

    logic        clk;
    logic        srst;
    logic        ser_data;
    logic        ser_val;
    logic        ser_busy;
    logic [15:0] data_o;
    logic [3:0]  data_mod_o;
    logic        data_val_o;
    logic        busy_o;

    deserializer #(.WIDTH(16), .MOD_W(4)) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .ser_data_i     (ser_data),
        .ser_data_val_i (ser_val),
        .ser_busy_i     (ser_busy),
        .data_o         (data_o),
        .data_mod_o     (data_mod_o),
        .data_val_o     (data_val_o),
        .busy_o         (busy_o)
    );

`ifdef DESER_LSB_FIRST_EN
    localparam logic [15:0] E7    = 16'h0053;
    localparam logic [15:0] EA5C3 = 16'hC3A5;
    localparam logic [15:0] E0001 = 16'h8000;
`else
    localparam logic [15:0] E7    = 16'hca00;
    localparam logic [15:0] EA5C3 = 16'hA5C3;
    localparam logic [15:0] E0001 = 16'h0001;
`endif
    localparam logic [15:0] F7 = 16'b1100101_000000000;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  m;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (data_val_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got data %0h mod %0d at cycle %0d, expected no pulse",
                         data_o, data_mod_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_data", 32'(data_o), 32'(e.d));
                chk("pulse_mod", 32'(data_mod_o), 32'(e.m));
                chk("pulse_cycle", 32'(cyc), 32'(e.c));
                chk("pulse_busy_low", 32'(busy_o), 32'd0);
            end
        end
    end

    task automatic drive(input logic busy, input logic val, input logic b);
        ser_busy = busy;
        ser_val  = val;
        ser_data = b;
        last_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [3:0] m);
        exp_t e;
        e.d = d;
        e.m = m;
        e.c = last_cyc + 1;
        sb.push_back(e);
    endtask

    // Sends n bits MSB-first from bits[15]; 'gaps' val-low cycles inserted after bit index gap_after.
    task automatic send_bits(input logic [15:0] bits, input int n, input int gap_after, input int gaps);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, bits[15-i]);
            if (i == gap_after)
                for (int g = 0; g < gaps; g++) drive(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic end_frame(input logic [15:0] d, input logic [3:0] m, input logic expect_pulse);
        drive(1'b0, 1'b0, 1'b0);
        if (expect_pulse) push_exp(d, m);
    endtask

    initial begin
        srst     = 1'b0;
        ser_data = 1'b0;
        ser_val  = 1'b0;
        ser_busy = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("reset_data", 32'(data_o), 32'd0);
        chk("reset_mod", 32'(data_mod_o), 32'd0);
        chk("reset_val", 32'(data_val_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        srst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // 7-bit frame terminated by busy falling
        send_bits(F7, 7, -1, 0);
        end_frame(E7, 4'd7, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // full 16-bit frame completes on its last bit
        send_bits(16'hA5C3, 16, -1, 0);
        push_exp(EA5C3, 4'd0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // same 7-bit frame with 3 val-low gaps inside the envelope
        send_bits(F7, 7, 2, 3);
        end_frame(E7, 4'd7, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // 2-bit frame is dropped; val without busy is ignored
        send_bits(16'h8000, 2, -1, 0);
        end_frame(16'h0, 4'd0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("hold_data", 32'(data_o), 32'(E7));
        chk("hold_mod", 32'(data_mod_o), 32'd7);
        chk("hold_busy", 32'(busy_o), 32'd0);
        chk("hold_val", 32'(data_val_o), 32'd0);

        // reset mid-frame discards the partial frame
        send_bits(16'hF800, 5, -1, 0);
        srst = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        chk("midrst_data", 32'(data_o), 32'd0);
        chk("midrst_mod", 32'(data_mod_o), 32'd0);
        chk("midrst_val", 32'(data_val_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        srst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        send_bits(F7, 7, -1, 0);
        end_frame(E7, 4'd7, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // back-to-back 16-bit frames, no idle cycle between them
        send_bits(16'hFFFF, 16, -1, 0);
        push_exp(16'hFFFF, 4'd0);
        send_bits(16'h0001, 16, -1, 0);
        push_exp(E0001, 4'd0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
